// File: rtl/multiword_add_seq.sv
// Wide add/subtract built from one shared N-bit adder, one word per cycle, LSB word first.
// The carry between words is held in a register; the parent owns the combinational adder.
module multiword_add_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N*K-1:0]   i_op_a,
  input  logic [N*K-1:0]   i_op_b,
  input  logic             i_sub,
  output logic [N-1:0]     o_add_a,
  output logic [N-1:0]     o_add_b,
  output logic             o_add_cin,
  input  logic [N-1:0]     i_add_sum,
  input  logic             i_add_cout,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N*K-1:0]   o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int unsigned W = N * K;
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    o_add_a   = '0;
    o_add_b   = '0;
    o_add_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = i_op_a;
          b_d     = i_sub ? ~i_op_b : i_op_b;
          carry_d = i_sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < K; k++) begin
          if (idx_q == IdxW'(k)) begin
            o_add_a           = a_q[k*N +: N];
            o_add_b           = b_q[k*N +: N];
            sum_d[k*N +: N]   = i_add_sum;
          end
        end
        o_add_cin = carry_q;
        carry_d   = i_add_cout;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = i_add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (i_add_sum[N-1] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ready     = (state_q == StIdle);
  assign o_valid     = (state_q == StDone);
  assign o_sum       = sum_q;
  assign o_carry_out = cout_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed corner cases plus a randomized scoreboard run
// against a plain W-bit arithmetic reference, with the shared adder modelled here.
`timescale 1ns/1ps
module tb_multiword_add_seq;
  localparam int unsigned N = 16;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid, o_ready, i_sub, i_ready;
  logic [W-1:0] i_op_a, i_op_b, o_sum;
  logic [N-1:0] o_add_a, o_add_b, i_add_sum;
  logic         o_add_cin, i_add_cout, o_valid, o_carry_out, o_overflow;
  logic [N:0]   add_res;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  logic rand_rdy = 1'b0;
  logic valid_prev = 1'b0;
  logic [W+1:0] sb_q[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // The parent's combinational N-bit adder.
  assign add_res    = {1'b0, o_add_a} + {1'b0, o_add_b} + {{N{1'b0}}, o_add_cin};
  assign i_add_sum  = add_res[N-1:0];
  assign i_add_cout = add_res[N];

  multiword_add_seq #(.N(N), .K(K)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_sub(i_sub),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_cin(o_add_cin),
    .i_add_sum(i_add_sum), .i_add_cout(i_add_cout),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum),
    .o_carry_out(o_carry_out), .o_overflow(o_overflow)
  );

  // Returns {overflow, carry_out, sum} from whole-word arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
    logic signed [W:0] sa, sb, sr;
    logic [W:0]        ua;
    logic [W-1:0]      r;
    logic              c, v;
    sa = $signed({a[W-1], a});
    sb = $signed({b[W-1], b});
    sr = sub ? sa - sb : sa + sb;
    ua = {1'b0, a} + {1'b0, b};
    r  = sub ? a - b : a + b;
    c  = sub ? (a >= b) : ua[W];
    v  = sr[W] != sr[W-1];
    return {v, c, r};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard monitor: latency on each new result, contents on each handshake.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      valid_prev = 1'b0;
    end else begin
      if (o_valid && !valid_prev) check("latency", W'(cyc - acc_cyc), W'(K));
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [W+1:0] e;
          e = sb_q.pop_front();
          check("sum", o_sum, e[W-1:0]);
          check("carry_out", W'(o_carry_out), W'(e[W]));
          check("overflow", W'(o_overflow), W'(e[W+1]));
        end
      end
      valid_prev = o_valid;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Offers one operation, waits (bounded) for acceptance, returns in the first RUN cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int unsigned n;
    i_op_a  = a;
    i_op_b  = b;
    i_sub   = sub;
    i_valid = 1'b1;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    check("accept_wait", W'(o_ready), W'(1));
    if (!o_ready) begin
      i_valid = 1'b0;
      return;
    end
    sb_q.push_back(ref_model(a, b, sub));
    @(posedge i_clk);
    #1;
    acc_cyc = cyc;
    i_valid = 1'b0;
    i_op_a  = rand_word();
    i_op_b  = rand_word();
    i_sub   = $urandom_range(0, 1) != 0;
  endtask

  task automatic drain();
    int unsigned n;
    i_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || !o_ready) && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("drain", W'(sb_q.size() == 0 && o_ready), W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] e;
    int unsigned  n;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_sub   = 1'b0;
    i_op_a  = '0;
    i_op_b  = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_sum", o_sum, '0);
    check("rst_add_a", W'(o_add_a), W'(0));
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // All-ones + 1 wraps to zero with carry out.
    i_ready = 1'b1;
    send({W{1'b1}}, 64'd1, 1'b0);
    drain();
    check("t1_sum", o_sum, 64'h0);
    check("t1_cout", W'(o_carry_out), W'(1));
    check("t1_ovf", W'(o_overflow), W'(0));

    // 0 - 1: carry-in of 1 on word 0, inverted B.
    send(64'h0, 64'h1, 1'b1);
    check("t2_cin_word0", W'(o_add_cin), W'(1));
    check("t2_add_b_word0", W'(o_add_b), W'(16'hFFFE));
    drain();
    check("t2_sum", o_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_cout", W'(o_carry_out), W'(0));

    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    drain();
    check("t3_sum", o_sum, 64'h8000_0000_0000_0000);
    check("t3_ovf", W'(o_overflow), W'(1));
    send(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    drain();
    check("t3b_sum", o_sum, 64'h7FFF_FFFF_FFFF_FFFF);
    check("t3b_ovf", W'(o_overflow), W'(1));
    check("t3b_cout", W'(o_carry_out), W'(1));

    // Backpressure: result must hold while inputs churn.
    i_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    e = ref_model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("bp_valid_seen", W'(o_valid), W'(1));
    repeat (5) begin
      @(posedge i_clk);
      #1;
      i_valid = $urandom_range(0, 1) != 0;
      i_op_a  = rand_word();
      i_op_b  = rand_word();
      i_sub   = $urandom_range(0, 1) != 0;
      @(negedge i_clk);
      check("bp_sum_hold", o_sum, e[W-1:0]);
      check("bp_flags_hold", W'({o_overflow, o_carry_out}), W'(e[W+1:W]));
      check("bp_ready_low", W'(o_ready), W'(0));
      check("bp_valid_high", W'(o_valid), W'(1));
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_ready_after_release", W'(o_ready), W'(1));
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    drain();
    check("bp_b2b_sum", o_sum, 64'h2222_2222_2222_2211);
    check("bp_b2b_cout", W'(o_carry_out), W'(0));

    // Asynchronous reset in the second RUN cycle.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_sum", o_sum, '0);
    check("mid_rst_valid", W'(o_valid), W'(0));
    check("mid_rst_flags", W'({o_carry_out, o_overflow}), W'(0));
    check("mid_rst_add", W'({o_add_a, o_add_b, o_add_cin}), W'(0));
    check("mid_rst_ready", W'(o_ready), W'(1));
    sb_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    drain();
    check("post_rst_sum", o_sum, 64'h0000_0000_0001_0000);
    check("post_rst_cout", W'(o_carry_out), W'(0));

    // Randomized regression with corner-biased operands and random gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      logic [W-1:0] a, b;
      a = rand_word();
      b = rand_word();
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = {W{1'b1}};
        2: b = 64'h8000_0000_0000_0000;
        3: b = 64'h7FFF_FFFF_FFFF_FFFF;
        4: b = a;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) begin
        @(posedge i_clk);
        #1;
      end
      send(a, b, $urandom_range(0, 1) != 0);
    end
    rand_rdy = 1'b0;
    @(posedge i_clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
